// File: rtl/alarm_controller.sv
// Alarm controller: debounces a level trigger, drives a blinking siren with a
// saturating alarm tally, and ignores the trigger for a holdoff window after disarm.
module alarm_controller #(
  parameter int CONFIRM_CYCLES = 4,
  parameter int BLINK_HALF     = 2,
  parameter int HOLDOFF_CYCLES = 8
) (
  input  logic       clk_2,
  input  logic       reset_n,
  input  logic       trigger,
  input  logic       disarm,
  output logic       alarm_out,
  output logic [1:0] state,
  output logic [3:0] event_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    CONFIRM = 2'b01,
    ALARM   = 2'b10,
    HOLDOFF = 2'b11
  } state_t;

  localparam logic [7:0] CONF_LAST  = 8'(CONFIRM_CYCLES - 1);
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_HALF - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLDOFF_CYCLES - 1);

  state_t     cur, nxt;
  logic [7:0] conf_cnt, blink_cnt, hold_cnt;
  logic [7:0] conf_nxt, blink_nxt, hold_nxt;
  logic       alarm_nxt;
  logic [3:0] count_nxt;

  assign state = cur;

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      cur         <= IDLE;
      conf_cnt    <= '0;
      blink_cnt   <= '0;
      hold_cnt    <= '0;
      alarm_out   <= 1'b0;
      event_count <= '0;
    end else begin
      cur         <= nxt;
      conf_cnt    <= conf_nxt;
      blink_cnt   <= blink_nxt;
      hold_cnt    <= hold_nxt;
      alarm_out   <= alarm_nxt;
      event_count <= count_nxt;
    end
  end

  always_comb begin
    nxt = cur;
    case (cur)
      IDLE:    if (trigger) nxt = CONFIRM;
      CONFIRM: begin
        if (!trigger)                  nxt = IDLE;
        else if (conf_cnt == CONF_LAST) nxt = ALARM;
      end
      ALARM:   if (disarm && !trigger) nxt = HOLDOFF;
      HOLDOFF: if (hold_cnt == HOLD_LAST) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Counters not owned by the current state fall back to zero.
  always_comb begin
    conf_nxt  = '0;
    blink_nxt = '0;
    hold_nxt  = '0;
    alarm_nxt = 1'b0;
    count_nxt = event_count;
    case (cur)
      IDLE: if (trigger) conf_nxt = 8'd1;
      CONFIRM: begin
        if (trigger && conf_cnt != CONF_LAST) begin
          conf_nxt = conf_cnt + 8'd1;
        end else if (trigger) begin
          alarm_nxt = 1'b1;
          if (event_count != 4'd15) count_nxt = event_count + 4'd1;
        end
      end
      ALARM: begin
        if (nxt != HOLDOFF) begin
          if (blink_cnt == BLINK_LAST) begin
            alarm_nxt = ~alarm_out;
          end else begin
            alarm_nxt = alarm_out;
            blink_nxt = blink_cnt + 8'd1;
          end
        end
      end
      HOLDOFF: if (hold_cnt != HOLD_LAST) hold_nxt = hold_cnt + 8'd1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller at default parameters.
module tb_alarm_controller;
  logic       clk_2 = 1'b0;
  logic       reset_n = 1'b0;
  logic       trigger = 1'b0;
  logic       disarm = 1'b0;
  logic       alarm_out;
  logic [1:0] state;
  logic [3:0] event_count;

  int checks = 0;
  int errors = 0;

  alarm_controller dut (
    .clk_2(clk_2), .reset_n(reset_n), .trigger(trigger), .disarm(disarm),
    .alarm_out(alarm_out), .state(state), .event_count(event_count)
  );

  always #5 clk_2 = ~clk_2;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_2);
    #1;
  endtask

  task automatic step_st(input string tag, input int exp_st);
    step();
    check(tag, int'(state), exp_st);
  endtask

  initial begin
    int trig_pat[8];
    int st_pat[8];
    int blink_exp[5];

    #2;
    check("rst_state", int'(state), 0);
    check("rst_alarm", int'(alarm_out), 0);
    check("rst_count", int'(event_count), 0);
    @(negedge clk_2);
    reset_n = 1'b1;

    // confirm latency: three CONFIRM samples, ALARM on the fourth
    trigger = 1'b1;
    step_st("conf1", 1);
    step_st("conf2", 1);
    step_st("conf3", 1);
    step_st("alarm_entry", 2);
    check("alarm_entry_out", int'(alarm_out), 1);
    check("alarm_entry_count", int'(event_count), 1);

    // blink with trigger held; disarm ignored while trigger is high
    blink_exp = '{1, 0, 0, 1, 1};
    for (int i = 0; i < 5; i++) begin
      disarm = (i == 1 || i == 2);
      step_st("blink_state", 2);
      check("blink_out", int'(alarm_out), blink_exp[i]);
    end

    // disarm exit, holdoff ignores trigger for 8 cycles
    trigger = 1'b0; disarm = 1'b1;
    step_st("holdoff_entry", 3);
    check("holdoff_out", int'(alarm_out), 0);
    trigger = 1'b1; disarm = 1'b0;
    for (int i = 0; i < 7; i++) begin
      step_st("holdoff_hold", 3);
      check("holdoff_out_hold", int'(alarm_out), 0);
    end
    step_st("holdoff_exit", 0);
    step_st("post_holdoff_conf", 1);
    check("count_after_first", int'(event_count), 1);

    // aborted confirmation, with disarm asserted to show it is ignored
    trigger = 1'b0;
    step_st("back_idle", 0);
    trig_pat = '{1, 1, 1, 0, 1, 1, 1, 1};
    st_pat   = '{1, 1, 1, 0, 1, 1, 1, 2};
    disarm = 1'b1;
    for (int i = 0; i < 8; i++) begin
      trigger = trig_pat[i][0];
      step_st("abort_pat", st_pat[i]);
    end
    check("abort_count", int'(event_count), 2);

    trigger = 1'b0;
    step_st("exit2", 3);
    disarm = 1'b0;
    repeat (8) step();
    check("idle2", int'(state), 0);

    // 15 more alarms: tally saturates at 15
    for (int n = 0; n < 15; n++) begin
      trigger = 1'b1;
      repeat (4) step();
      trigger = 1'b0; disarm = 1'b1;
      step();
      disarm = 1'b0;
      repeat (8) step();
    end
    check("sat_count", int'(event_count), 15);
    check("sat_idle", int'(state), 0);

    trigger = 1'b1;
    repeat (4) step();
    check("sat_alarm_state", int'(state), 2);
    check("sat_hold", int'(event_count), 15);

    // asynchronous reset mid-ALARM, between edges
    #2;
    reset_n = 1'b0;
    #1;
    check("async_state", int'(state), 0);
    check("async_alarm", int'(alarm_out), 0);
    check("async_count", int'(event_count), 0);
    @(negedge clk_2);
    reset_n = 1'b1;
    step_st("post_reset_conf", 1);
    check("post_reset_count", int'(event_count), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alarm_controller.md
ALARM_CONTROLLER -- requirements
Module: alarm_controller

Interface
- REQ-001 Parameter CONFIRM_CYCLES, default 4: consecutive high samples of trigger required to raise the alarm (legal range 2..255).
- REQ-002 Parameter BLINK_HALF, default 2: cycles per half-period of the siren blink (legal range 1..255).
- REQ-003 Parameter HOLDOFF_CYCLES, default 8: cycles trigger is ignored after disarm (legal range 1..255).
- REQ-004 clk_2  input  1  single clock; all state updates on the rising edge.
- REQ-005 reset_n  input  1  reset, asynchronous, active-low.
- REQ-006 trigger  input  1  alarm condition from the upstream combinational alarm logic (e.g. vault door open and switch armed), level-sensitive.
- REQ-007 disarm  input  1  operator acknowledge, level-sensitive, sampled on clk_2.
- REQ-008 alarm_out  output  1  siren/LED drive, registered.
- REQ-009 state  output  2  current FSM state encoding, registered.
- REQ-010 event_count  output  4  number of confirmed alarms, registered, saturating.

Function
- REQ-011 FSM states and encodings: IDLE=2'b00, CONFIRM=2'b01, ALARM=2'b10, HOLDOFF=2'b11; state output equals the current state.
- REQ-012 IDLE: alarm_out=0; trigger=1 -> CONFIRM with confirm counter=1; trigger=0 -> stay.
- REQ-013 CONFIRM: trigger=0 -> IDLE, counter cleared; trigger=1 and counter==CONFIRM_CYCLES-1 -> ALARM; otherwise counter+1.
- REQ-014 Latency: with trigger held high from edge N, state reads ALARM after edge N+CONFIRM_CYCLES-1 (defaults: 4th high sample).
- REQ-015 A single low trigger sample in CONFIRM aborts; confirmation restarts from 1 on the next high sample.
- REQ-016 Entry into ALARM: alarm_out=1, blink counter=0, event_count+1 on the same edge.
- REQ-017 event_count saturates at 15; no wrap to 0.
- REQ-018 ALARM blink: each cycle in ALARM, blink counter==BLINK_HALF-1 -> toggle alarm_out and clear counter; otherwise counter+1 (defaults: 1,1,0,0,1,1,...).
- REQ-019 ALARM exit: disarm=1 and trigger=0 on the same edge -> HOLDOFF, alarm_out=0, holdoff counter=0.
- REQ-020 disarm=1 while trigger=1 in ALARM: ignored; state and blink sequence continue unchanged.
- REQ-021 HOLDOFF: alarm_out=0; trigger ignored; counter+1 per cycle; counter==HOLDOFF_CYCLES-1 -> IDLE.
- REQ-022 disarm is ignored in IDLE, CONFIRM and HOLDOFF.
- REQ-023 Counter widths: 8 bits each; no counter exceeds its parameter bound.
- REQ-024 Encodings not listed in REQ-011 are unreachable.

Reset
- REQ-025 reset_n=0: state=IDLE, alarm_out=0, event_count=0, all internal counters=0, immediately and independent of clk_2.
- REQ-026 reset_n asserted in any state (including mid-CONFIRM or mid-ALARM): the operation is aborted with no event_count change beyond REQ-025.
- REQ-027 After reset_n deasserts, the first edge evaluates from IDLE.

Verification
- REQ-028 Defaults, trigger=1 for 4 cycles: state 01,01,01 then 10; alarm_out=1; event_count=1.
- REQ-029 Trigger pattern 1,1,1,0,1,1,1,1: state returns to IDLE on the 0 sample; ALARM is reached only after the final 4 highs; event_count=1.
- REQ-030 In ALARM with trigger=1: alarm_out sequence 1,1,0,0,1,1; disarm=1 during it gives no state change.
- REQ-031 In ALARM, trigger=0 and disarm=1: HOLDOFF and alarm_out=0 next edge; trigger=1 during 8 holdoff cycles ignored; IDLE after 8th cycle; then CONFIRM on the next high.
- REQ-032 Run 17 confirmed alarm/disarm cycles: event_count reads 15 and holds.
- REQ-033 Assert reset_n=0 mid-ALARM between clock edges: alarm_out=0, state=00 and event_count=0 without waiting for an edge.
